// File: rtl/msg_bit_feeder_pkg.sv
// Shared definitions for the message bit feeder: FSM encoding and widths.
package msg_bit_feeder_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEFAULT_BPS = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/msg_bit_feeder_byte_buffer.sv
// Two-entry message byte store: an MSB-first shift register plus one pending byte.
module msg_byte_buffer
    import msg_bit_feeder_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              ready_o,
    input  logic              pop_i,
    output logic              bit_o,
    output logic              avail_o
);

    localparam logic [3:0] CNT_FULL = 4'd8;
    localparam logic [3:0] CNT_ZERO = 4'd0;
    localparam logic [3:0] CNT_ONE  = 4'd1;

    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;

    assign ready_o = !pend_valid_q;
    assign bit_o   = shreg_q[BYTE_W-1];
    assign avail_o = (cnt_q != CNT_ZERO);

    // Pop first, then refill from the pending slot, then place a pushed byte
    // wherever the post-refill state leaves room.
    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (pop_i && (cnt_q != CNT_ZERO)) begin
            shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_ONE;
        end else begin
            shreg_d = shreg_q;
        end
        if ((cnt_d == CNT_ZERO) && pend_valid_q) begin
            shreg_d      = pend_q;
            cnt_d        = CNT_FULL;
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        if (push_i && !pend_valid_q) begin
            if (cnt_d == CNT_ZERO) begin
                shreg_d = byte_i;
                cnt_d   = CNT_FULL;
            end else begin
                pend_d       = byte_i;
                pend_valid_d = 1'b1;
            end
        end else begin
            pend_d = pend_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            shreg_q      <= {BYTE_W{1'b0}};
            cnt_q        <= CNT_ZERO;
            pend_q       <= {BYTE_W{1'b0}};
            pend_valid_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule

// File: rtl/msg_bit_feeder.sv
// Serializes message bytes MSB-first onto audio samples and hands each
// sample/bit pair to the LSB embedder with an enable/done handshake.
module msg_bit_feeder
    import msg_bit_feeder_pkg::*;
#(
    parameter int BPS   = DEFAULT_BPS,
    parameter int LEN_W = 16
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_msg_start,
    input  logic [LEN_W-1:0]  in_msg_len,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_byte_valid,
    output logic              out_byte_ready,
    input  logic [BPS-1:0]    in_sample,
    input  logic              in_sample_valid,
    output logic              out_sample_ready,
    output logic [BPS-1:0]    out_frame,
    output logic              out_message,
    output logic              out_enable,
    input  logic              in_done,
    output logic              out_busy,
    output logic              out_msg_done,
    output logic              out_underrun
);

    localparam logic [LEN_W+2:0] BITS_ONE = {{(LEN_W+2){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    fsm_state_e       state_q, state_d;
    logic [BPS-1:0]   frame_q, frame_d;
    logic             message_q, message_d;
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] acc_q, acc_d;
    logic [LEN_W+2:0] bits_left_q, bits_left_d;
    logic             msg_done_q, msg_done_d;
    logic             underrun_q, underrun_d;

    logic sample_accept_s;
    logic byte_accept_s;
    logic buf_ready_s;
    logic buf_bit_s;
    logic buf_avail_s;
    logic pop_s;

    msg_byte_buffer u_buf (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .clear_i (in_msg_start),
        .push_i  (byte_accept_s),
        .byte_i  (in_byte),
        .ready_o (buf_ready_s),
        .pop_i   (pop_s),
        .bit_o   (buf_bit_s),
        .avail_o (buf_avail_s)
    );

    // A start in the same cycle would clear the buffer, so no byte is taken then.
    assign out_byte_ready  = busy_q && buf_ready_s && (acc_q < len_q) && !in_msg_start;
    assign byte_accept_s   = in_byte_valid && out_byte_ready;
    assign sample_accept_s = in_sample_valid && out_sample_ready;

    assign out_frame    = frame_q;
    assign out_message  = message_q;
    assign out_busy     = busy_q;
    assign out_msg_done = msg_done_q;
    assign out_underrun = underrun_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = sample_accept_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = in_done ? ST_IDLE : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Holding ready low while done is high keeps enables away from a busy embedder.
    always_comb begin
        out_sample_ready = 1'b0;
        out_enable       = 1'b0;
        case (state_q)
            ST_IDLE:  out_sample_ready = !in_done;
            ST_ISSUE: out_enable       = 1'b1;
            ST_WAIT:  out_enable       = 1'b0;
            default:  out_sample_ready = 1'b0;
        endcase
    end

    // Bit selection, message counters and the start override.
    always_comb begin
        frame_d     = frame_q;
        message_d   = message_q;
        busy_d      = busy_q;
        len_d       = len_q;
        acc_d       = acc_q;
        bits_left_d = bits_left_q;
        msg_done_d  = 1'b0;
        underrun_d  = 1'b0;
        pop_s       = 1'b0;
        if (sample_accept_s) begin
            frame_d = in_sample;
            if (busy_q && buf_avail_s) begin
                message_d   = buf_bit_s;
                pop_s       = 1'b1;
                bits_left_d = bits_left_q - BITS_ONE;
                if (bits_left_q == BITS_ONE) begin
                    msg_done_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    busy_d = busy_q;
                end
            end else begin
                message_d  = in_sample[0];
                underrun_d = busy_q;
            end
        end else begin
            frame_d = frame_q;
        end
        if (byte_accept_s) begin
            acc_d = acc_q + LEN_ONE;
        end else begin
            acc_d = acc_q;
        end
        if (in_msg_start) begin
            len_d       = in_msg_len;
            acc_d       = LEN_ZERO;
            bits_left_d = {in_msg_len, 3'b000};
            busy_d      = (in_msg_len != LEN_ZERO);
            msg_done_d  = msg_done_d | (in_msg_len == LEN_ZERO);
        end else begin
            len_d = len_q;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            frame_q     <= {BPS{1'b0}};
            message_q   <= 1'b0;
            busy_q      <= 1'b0;
            len_q       <= LEN_ZERO;
            acc_q       <= LEN_ZERO;
            bits_left_q <= {(LEN_W+3){1'b0}};
            msg_done_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            frame_q     <= frame_d;
            message_q   <= message_d;
            busy_q      <= busy_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            bits_left_q <= bits_left_d;
            msg_done_q  <= msg_done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_msg_bit_feeder.sv
// Directed/randomized bench for msg_bit_feeder with an embedder stand-in and
// a queue-based reference model of the message bit stream.
module tb_msg_bit_feeder;

    localparam int BPS   = 24;
    localparam int LEN_W = 16;

    logic             in_clk = 1'b0;
    logic             in_rst;
    logic             in_msg_start;
    logic [LEN_W-1:0] in_msg_len;
    logic [7:0]       in_byte;
    logic             in_byte_valid;
    logic             out_byte_ready;
    logic [BPS-1:0]   in_sample;
    logic             in_sample_valid;
    logic             out_sample_ready;
    logic [BPS-1:0]   out_frame;
    logic             out_message;
    logic             out_enable;
    logic             in_done;
    logic             out_busy;
    logic             out_msg_done;
    logic             out_underrun;

    msg_bit_feeder #(.BPS(BPS), .LEN_W(LEN_W)) dut (
        .in_clk           (in_clk),
        .in_rst           (in_rst),
        .in_msg_start     (in_msg_start),
        .in_msg_len       (in_msg_len),
        .in_byte          (in_byte),
        .in_byte_valid    (in_byte_valid),
        .out_byte_ready   (out_byte_ready),
        .in_sample        (in_sample),
        .in_sample_valid  (in_sample_valid),
        .out_sample_ready (out_sample_ready),
        .out_frame        (out_frame),
        .out_message      (out_message),
        .out_enable       (out_enable),
        .in_done          (in_done),
        .out_busy         (out_busy),
        .out_msg_done     (out_msg_done),
        .out_underrun     (out_underrun)
    );

    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bits delivered but not yet used, bits still owed to the message.
    bit             q_bits[$];
    int             remaining = 0;
    int             acc_m     = 0;
    int             len_m     = 0;
    logic [BPS-1:0] exp_frame;
    logic           exp_bit;
    int             last_en   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BPS-1:0] rnd_sample();
        logic [31:0] r;
        r = $urandom();
        return r[BPS-1:0];
    endfunction

    task automatic model_start(input int len);
        q_bits.delete();
        remaining = 8 * len;
        acc_m     = 0;
        len_m     = len;
    endtask

    task automatic start_msg(input int len);
        logic [31:0] l;
        l = len;
        @(negedge in_clk);
        in_msg_start = 1'b1;
        in_msg_len   = l[LEN_W-1:0];
        @(posedge in_clk); #1;
        in_msg_start = 1'b0;
        model_start(len);
        chk("start_busy", 32'(out_busy), 32'(remaining > 0));
        chk("start_done", 32'(out_msg_done), 32'(len == 0));
        @(posedge in_clk); #1;
        chk("start_done_clear", 32'(out_msg_done), 32'(0));
    endtask

    task automatic offer_byte(input logic [7:0] b);
        bit er;
        @(negedge in_clk);
        er = (remaining > 0) && (q_bits.size() <= 8) && (acc_m < len_m);
        chk("byte_ready", 32'(out_byte_ready), 32'(er));
        in_byte       = b;
        in_byte_valid = 1'b1;
        @(posedge in_clk); #1;
        in_byte_valid = 1'b0;
        if (er) begin
            acc_m++;
            for (int i = 7; i >= 0; i--) q_bits.push_back(b[i]);
        end
    endtask

    task automatic accept_sample(input logic [BPS-1:0] s, input int exp_gap);
        int w;
        bit eu;
        bit ed;
        @(negedge in_clk);
        in_sample       = s;
        in_sample_valid = 1'b1;
        w = 0;
        while (!out_sample_ready && w < 50) begin
            @(negedge in_clk);
            w++;
        end
        chk("sample_ready_wait", 32'(out_sample_ready), 32'(1));
        @(posedge in_clk); #1;
        in_sample_valid = 1'b0;
        eu        = 1'b0;
        ed        = 1'b0;
        exp_frame = s;
        exp_bit   = s[0];
        if (remaining > 0) begin
            if (q_bits.size() > 0) begin
                exp_bit = q_bits.pop_front();
                remaining--;
                ed = (remaining == 0);
            end else begin
                eu = 1'b1;
            end
        end
        chk("enable_pulse", 32'(out_enable), 32'(1));
        chk("frame", 32'(out_frame), 32'(exp_frame));
        chk("message", 32'(out_message), 32'(exp_bit));
        chk("underrun", 32'(out_underrun), 32'(eu));
        chk("msg_done", 32'(out_msg_done), 32'(ed));
        chk("busy", 32'(out_busy), 32'(remaining > 0));
        if (exp_gap > 0) chk("spacing", 32'(cyc - last_en), 32'(exp_gap));
        last_en = cyc;
    endtask

    // Embedder stand-in: done rises three cycles after enable and stays for 'hold' cycles.
    task automatic finish_wait(input int hold, input int start_len);
        logic [31:0] l;
        for (int k = 2; k <= 4; k++) begin
            @(posedge in_clk); #1;
            if (k == 2 && start_len >= 0) begin
                l            = start_len;
                in_msg_start = 1'b1;
                in_msg_len   = l[LEN_W-1:0];
            end
            if (k == 3 && start_len >= 0) begin
                in_msg_start = 1'b0;
                model_start(start_len);
                chk("restart_busy", 32'(out_busy), 32'(1));
            end
            if (k == 4) in_done = 1'b1;
            chk("wait_enable_low", 32'(out_enable), 32'(0));
            chk("wait_frame_held", 32'(out_frame), 32'(exp_frame));
            chk("wait_bit_held", 32'(out_message), 32'(exp_bit));
            chk("wait_not_ready", 32'(out_sample_ready), 32'(0));
            chk("wait_pulses_low", 32'({out_msg_done, out_underrun}), 32'(0));
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge in_clk); #1;
            chk("done_enable_low", 32'(out_enable), 32'(0));
            if (k < hold - 1) chk("ready_while_done", 32'(out_sample_ready), 32'(0));
        end
        in_done = 1'b0;
        #1;
        chk("ready_after_done", 32'(out_sample_ready), 32'(1));
    endtask

    task automatic send_sample(input logic [BPS-1:0] s, input int exp_gap, input int hold);
        accept_sample(s, exp_gap);
        finish_wait(hold, -1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_frame"}, 32'(out_frame), 32'(0));
        chk({tag, "_message"}, 32'(out_message), 32'(0));
        chk({tag, "_enable"}, 32'(out_enable), 32'(0));
        chk({tag, "_busy"}, 32'(out_busy), 32'(0));
        chk({tag, "_pulses"}, 32'({out_msg_done, out_underrun}), 32'(0));
        chk({tag, "_byte_ready"}, 32'(out_byte_ready), 32'(0));
    endtask

    initial begin
        in_rst          = 1'b1;
        in_msg_start    = 1'b0;
        in_msg_len      = '0;
        in_byte         = 8'h00;
        in_byte_valid   = 1'b0;
        in_sample       = '0;
        in_sample_valid = 1'b0;
        in_done         = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        check_idle_outputs("reset");

        // len=1, byte A5 over zero samples; a second byte must be refused
        start_msg(1);
        offer_byte(8'hA5);
        offer_byte(8'h5A);
        for (int i = 0; i < 8; i++) send_sample('0, (i == 0) ? 0 : 5, 1);
        chk("msg1_busy_after", 32'(out_busy), 32'(0));

        // no message active: pass-through, done held for three cycles
        send_sample(24'h123457, 0, 3);

        // len=2 with the second byte withheld: four underruns then recovery
        start_msg(2);
        offer_byte(8'($urandom()));
        for (int i = 0; i < 12; i++) send_sample(rnd_sample(), (i == 0) ? 0 : 5, 1);
        offer_byte(8'($urandom()));
        for (int i = 0; i < 8; i++) send_sample(rnd_sample(), (i == 0) ? 0 : 5, 1);
        chk("msg2_busy_after", 32'(out_busy), 32'(0));

        // restart with len=3 while an earlier message's sample sits in WAIT
        start_msg(1);
        offer_byte(8'($urandom()));
        for (int i = 0; i < 3; i++) send_sample(rnd_sample(), (i == 0) ? 0 : 5, 1);
        accept_sample(rnd_sample(), 5);
        finish_wait(1, 3);
        offer_byte(8'($urandom()));
        offer_byte(8'($urandom()));
        offer_byte(8'($urandom()));
        for (int i = 0; i < 8; i++) send_sample(rnd_sample(), (i == 0) ? 0 : 5, 1);
        offer_byte(8'($urandom()));
        for (int i = 0; i < 16; i++) send_sample(rnd_sample(), (i == 0) ? 0 : 5, 1);
        chk("msg3_busy_after", 32'(out_busy), 32'(0));

        // reset during WAIT abandons the handshake
        start_msg(1);
        offer_byte(8'h3C);
        accept_sample(rnd_sample(), 0);
        @(posedge in_clk); #1;
        in_rst = 1'b1;
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        check_idle_outputs("midwait_reset");
        model_start(0);
        @(posedge in_clk); #1;
        chk("post_reset_enable", 32'(out_enable), 32'(0));

        // zero-length message: done next cycle, never busy
        start_msg(0);
        send_sample(rnd_sample(), 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msg_bit_feeder.md
# msg_bit_feeder

Upstream stage of the LSB-embedding chain. It accepts message bytes and audio samples and serializes the message MSB-first, one bit per sample. It presents each sample plus its message bit to the LSB embedder with a one-cycle enable, then holds both stable until the embedder reports done. Samples arriving with no message active, or during a bit underrun, are passed through with their original LSB, so they are not altered.

## Interface
- BPS, 24, bits per sample
- LEN_W, 16, width of message length in bytes
- in_clk  in  1  clock
- in_rst  in  1  reset, synchronous, active-high
- in_msg_start  in  1  pulse: load in_msg_len, clear byte buffer and counters, begin message
- in_msg_len  in  LEN_W  message length in bytes, sampled on in_msg_start
- in_byte  in  8  message byte
- in_byte_valid  in  1  in_byte valid
- out_byte_ready  out  1  byte accepted when in_byte_valid && out_byte_ready
- in_sample  in  BPS  audio sample
- in_sample_valid  in  1  in_sample valid
- out_sample_ready  out  1  sample accepted when in_sample_valid && out_sample_ready
- out_frame  out  BPS  registered sample to embedder in_frame
- out_message  out  1  registered bit to embedder in_message
- out_enable  out  1  one-cycle pulse to embedder in_enable
- in_done  in  1  embedder out_ready (level)
- out_busy  out  1  message active
- out_msg_done  out  1  one-cycle pulse after the last message bit is issued
- out_underrun  out  1  one-cycle pulse: sample issued while busy with no bit available

## Operation
- FSM states are IDLE, ISSUE and WAIT.
  - IDLE: out_sample_ready = (in_done == 0). On accept, register in_sample into out_frame and the selected bit into out_message, then go to ISSUE.
  - ISSUE: out_enable = 1 for exactly this cycle. Go to WAIT.
  - WAIT: hold out_frame and out_message. On in_done == 1, go to IDLE.
- Bit selection on accept:
  - If busy and a bit is available: use the shift register MSB, shift left, and decrement bits_left.
  - If busy and no bit is available: use in_sample[0] and pulse out_underrun.
  - If not busy: use in_sample[0].
- Byte buffer is 2-entry: an 8-bit shift register with a 0..8 bit count, plus one pending byte.
  - out_byte_ready = busy && !pend_valid && (bytes_accepted < len).
  - When the shift register empties on a bit consume and the pending byte is valid, the pending byte moves into the shift register in the same cycle.
- Counters:
  - bits_left = 8*len, LEN_W+3 bits wide.
  - When bits_left hits 0 on a consume: pulse out_msg_done, busy = 0.
- in_msg_start:
  - In any state it resets the buffer, counters and busy = 1, in the same cycle.
  - It does not disturb an FSM handshake in flight; the held frame and bit complete unchanged.
  - With in_msg_len = 0: busy stays 0 and out_msg_done pulses the next cycle.
- Bytes offered beyond len are not accepted (ready stays low).
- Simultaneous byte accept and bit consume are both honoured in one cycle.

## Timing
- Reset values: all outputs 0, state IDLE, busy 0, buffers empty.
- Reset mid-handshake abandons it: out_enable is low from the next cycle.
- Accept in cycle T gives out_enable high in T+1 and out_frame/out_message valid from T+1.
- With the standard embedder, in_done is high in T+4 and the FSM is in IDLE in T+5. Minimum spacing is 5 cycles per sample.
- The next out_enable is never issued while in_done == 1, which guarantees the embedder is back in its idle state.
- out_msg_done and out_underrun are registered and asserted in T+1, aligned with out_enable.

## Structure
- Shared package holds:
  - the FSM state encoding (2 bits: IDLE, ISSUE, WAIT)
  - the byte width constant 8
  - the default BPS
- One sub-module: msg_byte_buffer. It contains the 2-entry byte buffer, shift register and bit counter, with interface push/byte/ready, pop/bit/avail and clear.
- The top level holds the FSM, message counters and sample registers.

## Test plan
- Start with len=1 and byte 0xA5, then 8 samples of 0x000000. Required: out_message sequence 1,0,1,0,0,1,0,1; out_msg_done with the 8th out_enable; out_busy low afterwards.
- No message active, sample 0x123457. Required: out_frame = 0x123457, out_message = 1, out_enable one cycle, next out_sample_ready only after in_done falls.
- len=2 with the second byte withheld for 12 samples. Required: out_underrun on samples 9–12, each with out_message = in_sample[0]; the remaining bits follow once the byte arrives.
- Embedder model returning in_done 3 cycles after enable. Required: out_frame and out_message stable through WAIT, 5-cycle sample spacing, no out_enable while in_done == 1.
- in_msg_start (len=3) asserted during WAIT of an earlier message. Required: the held frame completes unchanged, and the next sample carries the MSB of the new first byte.
- Reset mid-WAIT, and start with len=0. Required: all outputs 0 after reset; out_msg_done one cycle after the start; busy stays 0.
